// File: rtl/guess_round_controller.sv
// guess_round_controller
//   Sequences one round of the number-guessing game around the digit-entry
//   block. It picks the secret from a free-running BCD counter, sets the digit
//   count, gates user input, judges each guess, counts the remaining attempts
//   and reports win or lose.
//
// Optional feature (macro GUESS_HINT_EN):
//   defined   -> hint_high / hint_low report whether the last valid guess was
//                above or below the secret.
//   undefined -> hint_high / hint_low are tied low and no comparator is built.
//
// Ports:
//   clk            system clock
//   restart        asynchronous active-low reset
//   start          level button, rising edge starts or aborts a round
//   submit         level button, rising edge submits the current guess
//   mode_sel[1:0]  requested digit count 1..3 (0 is treated as 1)
//   digit_1/2/3    current BCD guess, digit_1 is the ones digit
//   max_digits     digit count fed to digit entry
//   input_en       high only while in GUESS
//   clear_digits   one-cycle pulse as a new round begins (visible during ARM)
//   attempts_left  attempts remaining in the round
//   state_out      IDLE=0 ARM=1 GUESS=2 CHECK=3 WIN=4 LOSE=5
//   win / lose     high while in WIN / LOSE
//   hint_high/low  last guess was above / below the secret
module guess_round_controller #(
  parameter int MAX_ATTEMPTS = 7,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          restart,
  input  logic          start,
  input  logic          submit,
  input  logic [1:0]    mode_sel,
  input  logic [3:0]    digit_1,
  input  logic [3:0]    digit_2,
  input  logic [3:0]    digit_3,
  output logic [1:0]    max_digits,
  output logic          input_en,
  output logic          clear_digits,
  output logic [AW-1:0] attempts_left,
  output logic [2:0]    state_out,
  output logic          win,
  output logic          lose,
  output logic          hint_high,
  output logic          hint_low
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_GUESS = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam logic [AW-1:0] ATT_INIT = AW'(MAX_ATTEMPTS);

  state_t        r_state, w_next;
  logic          r_start_prev, r_submit_prev;
  logic          w_start_press, w_submit_press, w_round_start, w_submit_take;
  logic [3:0]    r_cnt_d1, r_cnt_d2, r_cnt_d3;
  logic [11:0]   r_secret, r_guess;
  logic [1:0]    r_max_digits, w_mode_digits;
  logic [AW-1:0] r_attempts, w_att_dec;
  logic          r_clear;
  logic          w_guess_bad, w_match;

  // Digits above the active digit count are forced to zero so that stale
  // entry digits never influence the secret or the guess.
  function automatic logic [11:0] mask_digits(input logic [1:0] n,
                                              input logic [3:0] d3,
                                              input logic [3:0] d2,
                                              input logic [3:0] d1);
    mask_digits = {(n == 2'd3) ? d3 : 4'd0, (n >= 2'd2) ? d2 : 4'd0, d1};
  endfunction

  // Previous-value registers start at 0, so a button held through reset
  // release is seen as one press on the first clock.
  assign w_start_press  = start  & ~r_start_prev;
  assign w_submit_press = submit & ~r_submit_prev;
  assign w_round_start  = w_start_press &&
                          (r_state == S_IDLE || r_state == S_GUESS ||
                           r_state == S_WIN  || r_state == S_LOSE);
  // start has priority over submit in GUESS
  assign w_submit_take  = w_submit_press && !w_start_press && (r_state == S_GUESS);
  assign w_mode_digits  = (mode_sel == 2'd0) ? 2'd1 : mode_sel;
  assign w_att_dec      = r_attempts - AW'(1);
  assign w_guess_bad    = (r_guess[11:8] > 4'd9) || (r_guess[7:4] > 4'd9) ||
                          (r_guess[3:0] > 4'd9);
  assign w_match        = !w_guess_bad && (r_guess == r_secret);

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_start_prev  <= 1'b0;
      r_submit_prev <= 1'b0;
    end else begin
      r_start_prev  <= start;
      r_submit_prev <= submit;
    end
  end

  // Free-running 000..999 BCD counter; frozen during CHECK.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_cnt_d1 <= 4'd0;
      r_cnt_d2 <= 4'd0;
      r_cnt_d3 <= 4'd0;
    end else if (r_state != S_CHECK) begin
      if (r_cnt_d1 == 4'd9) begin
        r_cnt_d1 <= 4'd0;
        if (r_cnt_d2 == 4'd9) begin
          r_cnt_d2 <= 4'd0;
          r_cnt_d3 <= (r_cnt_d3 == 4'd9) ? 4'd0 : r_cnt_d3 + 4'd1;
        end else begin
          r_cnt_d2 <= r_cnt_d2 + 4'd1;
        end
      end else begin
        r_cnt_d1 <= r_cnt_d1 + 4'd1;
      end
    end
  end

  // Round data: digit count, secret, guess, attempts, clear pulse.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_max_digits <= 2'd1;
      r_secret     <= 12'd0;
      r_guess      <= 12'd0;
      r_attempts   <= '0;
      r_clear      <= 1'b0;
    end else begin
      r_clear <= w_round_start;
      if (w_round_start) begin
        r_max_digits <= w_mode_digits;
        r_secret     <= mask_digits(w_mode_digits, r_cnt_d3, r_cnt_d2, r_cnt_d1);
        r_attempts   <= ATT_INIT;
      end else begin
        if (w_submit_take)
          r_guess <= mask_digits(r_max_digits, digit_3, digit_2, digit_1);
        if (r_state == S_CHECK && !w_match)
          r_attempts <= w_att_dec;
      end
    end
  end

`ifdef GUESS_HINT_EN
  logic       r_hint_high, r_hint_low;
  logic [9:0] w_guess_val, w_secret_val;

  function automatic logic [9:0] bcd_value(input logic [11:0] d);
    bcd_value = 10'(d[11:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
  endfunction

  assign w_guess_val  = bcd_value(r_guess);
  assign w_secret_val = bcd_value(r_secret);

  // Hints are only meaningful for a guess made of valid BCD digits.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_hint_high <= 1'b0;
      r_hint_low  <= 1'b0;
    end else if (w_round_start) begin
      r_hint_high <= 1'b0;
      r_hint_low  <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_hint_high <= !w_guess_bad && (w_guess_val > w_secret_val);
      r_hint_low  <= !w_guess_bad && (w_guess_val < w_secret_val);
    end
  end

  assign hint_high = r_hint_high;
  assign hint_low  = r_hint_low;
`else
  assign hint_high = 1'b0;
  assign hint_low  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_press) w_next = S_ARM;
      S_ARM:   w_next = S_GUESS;
      S_GUESS: begin
        if (w_start_press)       w_next = S_ARM;
        else if (w_submit_press) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_match)                w_next = S_WIN;
        else if (w_att_dec == '0)   w_next = S_LOSE;
        else                        w_next = S_GUESS;
      end
      S_WIN:   if (w_start_press) w_next = S_ARM;
      S_LOSE:  if (w_start_press) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    state_out     = r_state;
    input_en      = (r_state == S_GUESS);
    win           = (r_state == S_WIN);
    lose          = (r_state == S_LOSE);
    max_digits    = r_max_digits;
    clear_digits  = r_clear;
    attempts_left = r_attempts;
  end

endmodule

// File: tb/tb_guess_round_controller.sv
module tb_guess_round_controller;

  logic       clk = 1'b0;
  logic       restart, start, submit;
  logic [1:0] mode_sel;
  logic [3:0] d1, d2, d3;

  logic [1:0] a_max, b_max;
  logic       a_ien, b_ien, a_clr, b_clr;
  logic [3:0] a_att, b_att;
  logic [2:0] a_st, b_st;
  logic       a_win, b_win, a_lose, b_lose;
  logic       a_hh, b_hh, a_hl, b_hl;

  int checks   = 0;
  int failures = 0;

`ifdef GUESS_HINT_EN
  localparam logic HINT = 1'b1;
`else
  localparam logic HINT = 1'b0;
`endif

  guess_round_controller #(.MAX_ATTEMPTS(7), .AW(4)) u_a (
    .clk(clk), .restart(restart), .start(start), .submit(submit),
    .mode_sel(mode_sel), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .max_digits(a_max), .input_en(a_ien), .clear_digits(a_clr),
    .attempts_left(a_att), .state_out(a_st), .win(a_win), .lose(a_lose),
    .hint_high(a_hh), .hint_low(a_hl));

  guess_round_controller #(.MAX_ATTEMPTS(2), .AW(4)) u_b (
    .clk(clk), .restart(restart), .start(start), .submit(submit),
    .mode_sel(mode_sel), .digit_1(d1), .digit_2(d2), .digit_3(d3),
    .max_digits(b_max), .input_en(b_ien), .clear_digits(b_clr),
    .attempts_left(b_att), .state_out(b_st), .win(b_win), .lose(b_lose),
    .hint_high(b_hh), .hint_low(b_hl));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s: observed=%0h", tag, obs);
    end
  endtask

  task automatic press_submit(input logic [3:0] g3, input logic [3:0] g2, input logic [3:0] g1);
    d3 = g3; d2 = g2; d1 = g1;
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  initial begin
    restart = 1'b0; start = 1'b0; submit = 1'b0;
    mode_sel = 2'd3; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
    repeat (2) tick();

    chk("rst_state", a_st === 3'd0, 32'(a_st));
    chk("rst_maxd", a_max === 2'd1, 32'(a_max));
    chk("rst_att", a_att === 4'd0, 32'(a_att));
    chk("rst_flags", {a_ien, a_clr, a_win, a_lose, a_hh, a_hl} === 6'd0,
        32'({a_ien, a_clr, a_win, a_lose, a_hh, a_hl}));

    restart = 1'b1;
    repeat (42) tick();
    start = 1'b1;
    tick();
    chk("arm_state", a_st === 3'd1, 32'(a_st));
    chk("arm_clear", a_clr === 1'b1, 32'(a_clr));
    chk("arm_maxd", a_max === 2'd3, 32'(a_max));
    chk("arm_att", a_att === 4'd7, 32'(a_att));
    chk("arm_ien", a_ien === 1'b0, 32'(a_ien));
    start = 1'b0;
    tick();
    chk("guess_state", a_st === 3'd2, 32'(a_st));
    chk("guess_ien", a_ien === 1'b1, 32'(a_ien));
    chk("guess_clear", a_clr === 1'b0, 32'(a_clr));

    press_submit(4'd0, 4'd5, 4'd0);
    chk("check_state", a_st === 3'd3, 32'(a_st));
    chk("check_ien", a_ien === 1'b0, 32'(a_ien));
    tick();
    chk("g050_state", a_st === 3'd2, 32'(a_st));
    chk("g050_att", a_att === 4'd6, 32'(a_att));
    chk("g050_hh", a_hh === HINT, 32'(a_hh));
    chk("g050_hl", a_hl === 1'b0, 32'(a_hl));
    chk("b_g050_att", b_att === 4'd1, 32'(b_att));
    chk("b_g050_state", b_st === 3'd2, 32'(b_st));

    press_submit(4'd0, 4'd5, 4'hC);
    tick();
    chk("gbad_state", a_st === 3'd2, 32'(a_st));
    chk("gbad_att", a_att === 4'd5, 32'(a_att));
    chk("gbad_hints", {a_hh, a_hl} === 2'd0, 32'({a_hh, a_hl}));
    chk("b_lose_state", b_st === 3'd5, 32'(b_st));
    chk("b_lose_flag", b_lose === 1'b1, 32'(b_lose));
    chk("b_lose_att", b_att === 4'd0, 32'(b_att));

    press_submit(4'd0, 4'd3, 4'd0);
    tick();
    chk("g030_att", a_att === 4'd4, 32'(a_att));
    chk("g030_hl", a_hl === HINT, 32'(a_hl));
    chk("g030_hh", a_hh === 1'b0, 32'(a_hh));

    press_submit(4'd0, 4'd4, 4'd2);
    tick();
    chk("win_state", a_st === 3'd4, 32'(a_st));
    chk("win_flag", a_win === 1'b1, 32'(a_win));
    chk("win_att", a_att === 4'd4, 32'(a_att));
    chk("win_hints", {a_hh, a_hl} === 2'd0, 32'({a_hh, a_hl}));
    chk("b_still_lose", b_st === 3'd5, 32'(b_st));

    press_submit(4'd0, 4'd5, 4'd0);
    tick();
    chk("win_hold_state", a_st === 3'd4, 32'(a_st));
    chk("win_hold_att", a_att === 4'd4, 32'(a_att));

    start = 1'b1;
    tick();
    chk("restart_a_state", a_st === 3'd1, 32'(a_st));
    chk("restart_a_att", a_att === 4'd7, 32'(a_att));
    chk("restart_b_state", b_st === 3'd1, 32'(b_st));
    chk("restart_b_att", b_att === 4'd2, 32'(b_att));
    chk("restart_clear", a_clr === 1'b1, 32'(a_clr));
    start = 1'b0;
    tick();
    chk("r2_guess", a_st === 3'd2, 32'(a_st));

    press_submit(4'd0, 4'd0, 4'hC);
    tick();
    chk("r2_miss_att", a_att === 4'd6, 32'(a_att));
    chk("r2_miss_hints", {a_hh, a_hl} === 2'd0, 32'({a_hh, a_hl}));
    start = 1'b1; submit = 1'b1;
    tick();
    chk("both_state", a_st === 3'd1, 32'(a_st));
    chk("both_att", a_att === 4'd7, 32'(a_att));
    chk("both_b_att", b_att === 4'd2, 32'(b_att));
    start = 1'b0; submit = 1'b0;
    tick();
    chk("both_guess", a_st === 3'd2, 32'(a_st));

    press_submit(4'd0, 4'd0, 4'hC);
    chk("midchk_state", a_st === 3'd3, 32'(a_st));
    restart = 1'b0;
    #1;
    chk("arst_state", a_st === 3'd0, 32'(a_st));
    chk("arst_att", a_att === 4'd0, 32'(a_att));
    chk("arst_maxd", a_max === 2'd1, 32'(a_max));
    chk("arst_flags", {a_ien, a_clr, a_win, a_lose, a_hh, a_hl} === 6'd0,
        32'({a_ien, a_clr, a_win, a_lose, a_hh, a_hl}));

    start = 1'b1; mode_sel = 2'd2;
    #2;
    restart = 1'b1;
    tick();
    chk("held_arm", a_st === 3'd1, 32'(a_st));
    chk("held_maxd", a_max === 2'd2, 32'(a_max));
    tick();
    chk("held_guess", a_st === 3'd2, 32'(a_st));
    tick();
    chk("held_norepeat", a_st === 3'd2, 32'(a_st));
    chk("held_att", a_att === 4'd7, 32'(a_att));
    start = 1'b0;

    restart = 1'b0; mode_sel = 2'd1;
    tick();
    restart = 1'b1;
    repeat (42) tick();
    start = 1'b1;
    tick();
    chk("m1_maxd", a_max === 2'd1, 32'(a_max));
    start = 1'b0;
    tick();
    press_submit(4'd0, 4'd4, 4'd2);
    tick();
    chk("m1_win", a_st === 3'd4, 32'(a_st));
    chk("m1_att", a_att === 4'd7, 32'(a_att));

    restart = 1'b0; mode_sel = 2'd0;
    tick();
    restart = 1'b1;
    repeat (42) tick();
    start = 1'b1;
    tick();
    chk("m0_maxd", a_max === 2'd1, 32'(a_max));
    start = 1'b0;
    tick();
    press_submit(4'd0, 4'd0, 4'd3);
    tick();
    chk("m0_miss_att", a_att === 4'd6, 32'(a_att));
    chk("m0_miss_hh", a_hh === HINT, 32'(a_hh));
    press_submit(4'd0, 4'd0, 4'd2);
    tick();
    chk("m0_win", a_st === 3'd4, 32'(a_st));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
